router_ilck_slice: RTL and testbench

- Parametrised, multi-channel interlocked register slice for the router tile.
- Successor to the single-bit set/reset flop primitive: CHANNELS independent lanes, each DATA_W bits wide, each with a 2-entry skid buffer and a valid/ready interlock.
- Ready is registered, so the slice breaks both forward and backward timing paths between router_wrap slices.
- Sits between router_wrap slice outputs and downstream crossbar or link inputs.

---
 rtl/router_ilck_pkg.sv | 28 ++
 rtl/router_ilck_lane.sv | 140 ++++++++++++++
 rtl/router_ilck_slice.sv | 61 ++++++
 tb/tb_router_ilck_slice.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/router_ilck_pkg.sv
`default_nettype none
// ============================================================================
// Module   : router_ilck_pkg
// Purpose  : Shared types and helpers for the router interlocked register
//            slice: the per-lane state encoding, default widths and the
//            lane bit-slice helper used to carve flat lane buses.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package router_ilck_pkg;

    // Lane occupancy: EMPTY (nothing held), ONE (main full), TWO (main + skid)
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } lane_state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 8;

    // LSB position of lane 'lane' inside a flat bus of 'width'-bit lanes
    function automatic int lane_lsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/router_ilck_lane.sv
`default_nettype none
// ============================================================================
// Module   : router_ilck_lane
// Purpose  : One lane of the interlocked register slice. A main register
//            feeds out_data; a skid register catches the single beat that can
//            arrive in the cycle the downstream stalls, which lets in_ready be
//            a flop rather than a combinational function of out_ready.
// Ports    : clk, reset_n (async active-low), flush (sync clear),
//            in_valid/in_data/in_ready (upstream), out_valid/out_data/
//            out_ready (downstream), stall_cnt (only with the macro below).
// Options  : ROUTER_ILCK_STALL_CNT_EN adds a saturating stall counter.
// Revision : 1.0 - initial release
// ============================================================================
module router_ilck_lane
    import router_ilck_pkg::*;
#(
    parameter int                DATA_W  = DEF_DATA_W,
    parameter int                CNT_W   = DEF_CNT_W,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
`ifdef ROUTER_ILCK_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    lane_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              push;
    logic              pop;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            // Flush wins over any same-cycle push or pop
            state_d = EMPTY;
            main_d  = RST_VAL;
            skid_d  = RST_VAL;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_d = ONE;
                        main_d  = in_data;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        state_d = TWO;
                        skid_d  = in_data;
                    end else if (push && pop) begin
                        main_d  = in_data;
                    end else if (pop) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only a pop can happen
                    if (pop) begin
                        state_d = ONE;
                        main_d  = skid_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    main_d  = RST_VAL;
                    skid_d  = RST_VAL;
                end
            endcase
        end
        // Handshake outputs are decoded from the next state and registered
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != TWO);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= EMPTY;
            main_q      <= RST_VAL;
            skid_q      <= RST_VAL;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = main_q;

`ifdef ROUTER_ILCK_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles the lane offers data that is not taken;
    // survives flush so stall history is kept across traffic clears.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_cnt_cfg;
    assign unused_cnt_cfg = ^CNT_W;
`endif

endmodule
`default_nettype wire

// File: rtl/router_ilck_slice.sv
`default_nettype none
// ============================================================================
// Module   : router_ilck_slice
// Purpose  : Multi-channel interlocked register slice. CHANNELS independent
//            lanes, each a 2-entry skid buffer with registered valid and
//            ready, breaking forward and backward timing paths.
// Ports    : clk, reset_n (async active-low), flush (sync clear),
//            in_valid[CHANNELS], in_data[CHANNELS*DATA_W], in_ready[CHANNELS],
//            out_valid[CHANNELS], out_data[CHANNELS*DATA_W],
//            out_ready[CHANNELS], stall_cnt[CHANNELS*CNT_W] (macro only).
//            Lane i occupies bits [i*W +: W] of every flat bus.
// Options  : ROUTER_ILCK_STALL_CNT_EN adds per-lane saturating stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module router_ilck_slice
    import router_ilck_pkg::*;
#(
    parameter int                DATA_W   = DEF_DATA_W,
    parameter int                CHANNELS = 4,
    parameter logic [DATA_W-1:0] RST_VAL  = '0,
    parameter int                CNT_W    = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [CHANNELS-1:0]        in_valid,
    input  logic [CHANNELS*DATA_W-1:0] in_data,
    output logic [CHANNELS-1:0]        in_ready,
    output logic [CHANNELS-1:0]        out_valid,
    output logic [CHANNELS*DATA_W-1:0] out_data,
    input  logic [CHANNELS-1:0]        out_ready
`ifdef ROUTER_ILCK_STALL_CNT_EN
    ,
    output logic [CHANNELS*CNT_W-1:0]  stall_cnt
`endif
);

    for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
        router_ilck_lane #(
            .DATA_W  (DATA_W),
            .CNT_W   (CNT_W),
            .RST_VAL (RST_VAL)
        ) u_lane (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush),
            .in_valid  (in_valid[i]),
            .in_data   (in_data[lane_lsb(i, DATA_W) +: DATA_W]),
            .in_ready  (in_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[lane_lsb(i, DATA_W) +: DATA_W]),
            .out_ready (out_ready[i])
`ifdef ROUTER_ILCK_STALL_CNT_EN
            ,
            .stall_cnt (stall_cnt[lane_lsb(i, CNT_W) +: CNT_W])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_router_ilck_slice.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_ilck_slice
// Purpose  : Self-checking bench for router_ilck_slice. Directed stimulus
//            pushes hand-computed expected beats into per-lane queues; an
//            independent negedge monitor compares every presented beat.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_ilck_slice;

    localparam int             DW = 8;
    localparam int             CH = 4;
    localparam int             CW = 4;
    localparam logic [DW-1:0]  RV = 8'hE7;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               flush;
    logic [CH-1:0]      in_valid;
    logic [CH*DW-1:0]   in_data;
    logic [CH-1:0]      in_ready;
    logic [CH-1:0]      out_valid;
    logic [CH*DW-1:0]   out_data;
    logic [CH-1:0]      out_ready;
`ifdef ROUTER_ILCK_STALL_CNT_EN
    logic [CH*CW-1:0]   stall_cnt;
`endif

    int total = 0;
    int bad   = 0;
    logic [DW-1:0] exp_q [CH][$];

    always #5 clk = ~clk;

    router_ilck_slice #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .RST_VAL  (RV),
        .CNT_W    (CW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
`ifdef ROUTER_ILCK_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_lane(input int i, input logic v, input logic [DW-1:0] d);
        in_valid[i]           = v;
        in_data[i*DW +: DW]   = d;
    endtask

    task automatic push_beat(input int i, input logic [DW-1:0] d);
        set_lane(i, 1'b1, d);
        exp_q[i].push_back(d);
    endtask

    // Scoreboard monitor: every presented beat must match the queue head;
    // the head is retired only when the beat is actually taken.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int i = 0; i < CH; i++) begin
                if (out_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_beat lane%0d: got %0h expected none", i, out_data[i*DW +: DW]);
                    end else begin
                        chk($sformatf("data_lane%0d", i), 32'(out_data[i*DW +: DW]), 32'(exp_q[i][0]));
                        if (out_ready[i]) void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        total++;
        bad++;
        $display("FAIL timeout: got no finish expected finish");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = '0;
        in_data   = '0;
        out_ready = '0;
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_in_ready",  32'(in_ready),  32'hF);
        chk("rst_out_data",  out_data,       {CH{RV}});
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // Lane 0 streaming at full rate
        out_ready = 4'b0001;
        push_beat(0, 8'h11); step();
        chk("l0_latency", 32'(out_valid[0]), 32'h1);
        chk("l0_ready_a", 32'(in_ready[0]),  32'h1);
        push_beat(0, 8'h22); step();
        chk("l0_ready_b", 32'(in_ready[0]),  32'h1);
        push_beat(0, 8'h33); step();
        chk("l0_ready_c", 32'(in_ready[0]),  32'h1);
        set_lane(0, 1'b0, 8'h00); step();
        chk("l0_drained", 32'(out_valid[0]), 32'h0);

        // Lane 1 backpressure, illegal offer while full is dropped
        out_ready = 4'b0000;
        push_beat(1, 8'hA1); step();
        chk("l1_ready_one", 32'(in_ready[1]), 32'h1);
        push_beat(1, 8'hA2); step();
        chk("l1_ready_two", 32'(in_ready[1]), 32'h0);
        set_lane(1, 1'b1, 8'hA3); step(); step();
        chk("l1_ready_hold", 32'(in_ready[1]), 32'h0);
        chk("l1_stable", 32'(out_data[1*DW +: DW]), 32'hA1);
        set_lane(1, 1'b0, 8'h00);
        out_ready[1] = 1'b1;
        step();
        chk("l1_ready_back", 32'(in_ready[1]), 32'h1);
        step(); step();
        chk("l1_drained", 32'(out_valid[1]), 32'h0);

        // Lane 2 held in TWO while lane 3 streams
        out_ready = 4'b1000;
        push_beat(2, 8'hB1); step();
        push_beat(2, 8'hB2); step();
        set_lane(2, 1'b1, 8'hB3);
        for (int k = 1; k <= 4; k++) begin
            push_beat(3, 8'(k)); step();
            chk($sformatf("l3_ready_%0d", k), 32'(in_ready[3]),  32'h1);
            chk($sformatf("l3_valid_%0d", k), 32'(out_valid[3]), 32'h1);
        end
        set_lane(3, 1'b0, 8'h00); step();
        chk("l3_drained", 32'(out_valid[3]), 32'h0);
        chk("l2_held_data",  32'(out_data[2*DW +: DW]), 32'hB1);
        chk("l2_held_ready", 32'(in_ready[2]), 32'h0);
        set_lane(2, 1'b0, 8'h00);
        out_ready[2] = 1'b1;
        step(); step(); step();
        chk("l2_drained", 32'(out_valid[2]), 32'h0);

        // Flush with same-cycle push while lane 0 is in TWO
        out_ready = 4'b0000;
        push_beat(0, 8'hC1); step();
        push_beat(0, 8'hC2); step();
        chk("l0_two_ready", 32'(in_ready[0]), 32'h0);
        flush = 1'b1;
        set_lane(0, 1'b1, 8'hC3);
        step();
        flush = 1'b0;
        set_lane(0, 1'b0, 8'h00);
        exp_q[0].delete();
        chk("flush_valid", 32'(out_valid), 32'h0);
        chk("flush_ready", 32'(in_ready),  32'hF);
        chk("flush_data",  out_data,       {CH{RV}});
        step(); step();
        chk("flush_no_beat", 32'(out_valid), 32'h0);

        // Asynchronous reset mid-transfer
        push_beat(1, 8'hD1); step();
        set_lane(1, 1'b0, 8'h00);
        chk("pre_rst_valid", 32'(out_valid[1]), 32'h1);
        #3 reset_n = 1'b0;
        #1;
        exp_q[1].delete();
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_ready", 32'(in_ready),  32'hF);
        chk("async_rst_data",  out_data,       {CH{RV}});
        @(negedge clk);
        reset_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(out_valid), 32'h0);
        out_ready = 4'b0010;
        push_beat(1, 8'hE1); step();
        chk("post_rst_first", 32'(out_valid[1]), 32'h1);
        set_lane(1, 1'b0, 8'h00); step();
        chk("post_rst_drain", 32'(out_valid[1]), 32'h0);

`ifdef ROUTER_ILCK_STALL_CNT_EN
        // Stall counter saturation and asynchronous clear
        out_ready = 4'b0000;
        push_beat(0, 8'hF1); step();
        set_lane(0, 1'b0, 8'h00);
        repeat (20) step();
        chk("stall_sat",    32'(stall_cnt[0 +: CW]),        32'hF);
        chk("stall_others", 32'(stall_cnt[CW +: 3*CW]),     32'h0);
        #3 reset_n = 1'b0;
        #1;
        exp_q[0].delete();
        chk("stall_clear",  32'(stall_cnt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        step();
`endif

        step();
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("queue_empty_l%0d", i), 32'(exp_q[i].size()), 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
